// File: rtl/jtag_tdr_bank_pkg.sv
// Shared types and helpers for the JTAG test data register bank.
package jtag_tdr_pkg;

  // Scan phase as seen by this bank; only CAP/SHF may end in a commit.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAP  = 2'd1,
    ST_SHF  = 2'd2
  } tdr_state_e;

  // All registers read-write unless the instance overrides it.
  localparam logic [15:0] DEF_RO_MASK = 16'h0000;

  // The shift counter must hold REG_W+1 so a long scan stays distinguishable.
  function automatic int cnt_w(input int reg_w);
    return $clog2(reg_w + 2);
  endfunction

endpackage

// File: rtl/jtag_tdr_bank_if.sv
// TAP-side DR control and serial path of the register bank.
interface jtag_tdr_bank_if #(
  parameter int SEL_W = 2
);
  logic             shift_dr_i;
  logic             capture_dr_i;
  logic             update_dr_i;
  logic             tdr_sel_i;
  logic [SEL_W-1:0] reg_sel_i;
  logic             tdi_i;
  logic             tdo_o;

  modport master (
    output shift_dr_i, capture_dr_i, update_dr_i, tdr_sel_i, reg_sel_i, tdi_i,
    input  tdo_o
  );

  modport slave (
    input  shift_dr_i, capture_dr_i, update_dr_i, tdr_sel_i, reg_sel_i, tdi_i,
    output tdo_o
  );
endinterface

// File: rtl/jtag_tdr_bank_shifter.sv
// Shared DR shift path: shift register, scan-length counter, negedge TDO.
module jtag_tdr_shifter
  import jtag_tdr_pkg::*;
#(
  parameter int REG_W = 32,
  parameter int CW    = cnt_w(REG_W)
) (
  input  logic             tclk,
  input  logic             test_logic_reset_i,
  input  logic             tdr_sel,
  input  logic             capture,
  input  logic             shift,
  input  logic [REG_W-1:0] cap_val,
  input  logic             tdi,
  output logic [REG_W-1:0] shift_q,
  output logic [CW-1:0]    bit_cnt,
  output logic             tdo
);

  // Load on capture, shift LSB-first; counter saturates one past REG_W.
  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (tdr_sel && capture) begin
      shift_q <= cap_val;
      bit_cnt <= '0;
    end else if (tdr_sel && shift) begin
      shift_q <= {tdi, shift_q[REG_W-1:1]};
      if (bit_cnt != CW'(REG_W + 1)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // TDO retimed to the falling edge; holds while the bank is not selected.
  always_ff @(negedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) tdo <= 1'b0;
    else if (tdr_sel)       tdo <= shift_q[0];
  end

endmodule

// File: rtl/jtag_tdr_bank.sv
// Bank of NUM_REGS test data registers behind one DR shift path.
// Register select is latched at capture; commits need an exact-length scan
// with the MSB write flag set, an in-range select and a read-write target.
module jtag_tdr_bank
  import jtag_tdr_pkg::*;
#(
  parameter int                  NUM_REGS = 4,
  parameter int                  REG_W    = 32,
  parameter logic [NUM_REGS-1:0] RO_MASK  = DEF_RO_MASK[NUM_REGS-1:0],
  parameter int                  SEL_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      tclk,
  input  logic                      test_logic_reset_i,
  jtag_tdr_bank_if.slave            tap,
  input  logic [NUM_REGS*REG_W-1:0] cap_i,
  output logic [NUM_REGS*REG_W-1:0] cfg_o,
  output logic [NUM_REGS-1:0]       upd_o,
  output logic                      len_err_o,
  output logic                      sel_err_o
);

  localparam int CW = cnt_w(REG_W);

  logic [NUM_REGS-1:0][REG_W-1:0] cfg_q;
  logic [NUM_REGS-1:0][REG_W-1:0] cap_arr;
  logic [REG_W-1:0]               cap_val;
  logic [REG_W-1:0]               shift_q;
  logic [CW-1:0]                  bit_cnt;
  logic [SEL_W-1:0]               sel_q;
  logic [NUM_REGS-1:0]            commit_oh;
  tdr_state_e                     state;
  logic                           cap_fire, shf_fire, upd_fire, scan_act, commit_rdy;

  assign cap_arr  = cap_i;
  assign cfg_o    = cfg_q;
  assign cap_fire = tap.tdr_sel_i & tap.capture_dr_i;
  assign shf_fire = tap.tdr_sel_i & tap.shift_dr_i;
  assign upd_fire = tap.tdr_sel_i & tap.update_dr_i;
  assign scan_act = (state != ST_IDLE);
  assign commit_rdy = upd_fire && scan_act && (bit_cnt == CW'(REG_W)) && shift_q[REG_W-1];

  // Capture source and commit target; an out-of-range index matches no slot,
  // so it captures zeros and never commits.
  always_comb begin
    cap_val   = '0;
    commit_oh = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (tap.reg_sel_i == SEL_W'(k)) cap_val = RO_MASK[k] ? cap_arr[k] : cfg_q[k];
      if (sel_q == SEL_W'(k) && !RO_MASK[k]) commit_oh[k] = commit_rdy;
    end
  end

  jtag_tdr_shifter #(.REG_W(REG_W), .CW(CW)) u_shf (
    .tclk               (tclk),
    .test_logic_reset_i (test_logic_reset_i),
    .tdr_sel            (tap.tdr_sel_i),
    .capture            (tap.capture_dr_i),
    .shift              (tap.shift_dr_i),
    .cap_val            (cap_val),
    .tdi                (tap.tdi_i),
    .shift_q            (shift_q),
    .bit_cnt            (bit_cnt),
    .tdo                (tap.tdo_o)
  );

  // Scan phase tracking; deselect abandons the scan in progress.
  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i)        state <= ST_IDLE;
    else if (!tap.tdr_sel_i)       state <= ST_IDLE;
    else if (cap_fire)             state <= ST_CAP;
    else if (shf_fire && scan_act) state <= ST_SHF;
    else if (upd_fire)             state <= ST_IDLE;
  end

  // Select latch and error flags, refreshed at capture.
  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      sel_q     <= '0;
      sel_err_o <= 1'b0;
      len_err_o <= 1'b0;
    end else if (cap_fire) begin
      sel_q     <= tap.reg_sel_i;
      sel_err_o <= (32'(tap.reg_sel_i) >= NUM_REGS);
      len_err_o <= 1'b0;
    end else if (upd_fire && scan_act && bit_cnt != CW'(REG_W)) begin
      len_err_o <= 1'b1;
    end
  end

  // Commit into the register file; the write flag itself is never stored.
  always_ff @(posedge tclk or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      cfg_q <= '0;
      upd_o <= '0;
    end else begin
      upd_o <= commit_oh;
      for (int k = 0; k < NUM_REGS; k++)
        if (commit_oh[k]) cfg_q[k] <= {1'b0, shift_q[REG_W-2:0]};
    end
  end

endmodule

// File: tb/tb_jtag_tdr_bank.sv
// Randomized bench for jtag_tdr_bank against a scan-level reference model.
module tb_jtag_tdr_bank;
  localparam int            N  = 3;
  localparam int            W  = 32;
  localparam logic [N-1:0]  RO = 3'b100;

  logic             tclk = 1'b0;
  logic             rst  = 1'b1;
  logic [N*W-1:0]   cap_i;
  logic [N*W-1:0]   cfg_o;
  logic [N-1:0]     upd_o;
  logic             len_err, sel_err;

  always #5 tclk = ~tclk;

  jtag_tdr_bank_if #(.SEL_W(2)) tap();

  jtag_tdr_bank #(.NUM_REGS(N), .REG_W(W), .RO_MASK(RO), .SEL_W(2)) dut (
    .tclk               (tclk),
    .test_logic_reset_i (rst),
    .tap                (tap.slave),
    .cap_i              (cap_i),
    .cfg_o              (cfg_o),
    .upd_o              (upd_o),
    .len_err_o          (len_err),
    .sel_err_o          (sel_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: register contents and the two sticky flags.
  logic [W-1:0] m_cfg [N];
  logic         m_len, m_sel;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [N*W-1:0] m_flat();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = m_cfg[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge tclk); #1;
  endtask

  // Full scan: capture sel, shift n bits of data LSB-first, update.
  task automatic scan(input int sel, input logic [63:0] data, input int n);
    logic [W-1:0] capv;
    logic         ro, commit;
    logic         exp_bit;
    ro   = (sel < N) ? RO[sel] : 1'b0;
    capv = (sel >= N) ? '0 : (ro ? cap_i[sel*W +: W] : m_cfg[sel]);
    tap.tdr_sel_i    = 1'b1;
    tap.reg_sel_i    = 2'(sel);
    tap.capture_dr_i = 1'b1;
    tick();
    tap.capture_dr_i = 1'b0;
    m_len = 1'b0;
    m_sel = (sel >= N);
    chk("cap_sel_err", sel_err, m_sel);
    chk("cap_len_clr", len_err, m_len);
    for (int i = 0; i < n; i++) begin
      tap.shift_dr_i = 1'b1;
      tap.tdi_i      = data[i];
      if (i == n/2 || $urandom_range(0, 3) == 0) tap.reg_sel_i = 2'($urandom);
      @(negedge tclk); #1;
      exp_bit = (i < W) ? capv[i] : data[i-W];
      chk("tdo", tap.tdo_o, exp_bit);
      @(posedge tclk); #1;
    end
    tap.shift_dr_i  = 1'b0;
    tap.update_dr_i = 1'b1;
    tick();
    tap.update_dr_i = 1'b0;
    commit = (n == W) && data[W-1] && (sel < N) && !ro;
    if (commit) m_cfg[sel] = {1'b0, data[W-2:0]};
    m_len = (n != W);
    chk("upd", upd_o, commit ? (N'(1) << sel) : N'(0));
    chk("cfg", cfg_o, m_flat());
    chk("len_err", len_err, m_len);
    chk("sel_err", sel_err, m_sel);
    tick();
    chk("upd_pulse", upd_o, 0);
  endtask

  initial begin
    int n, sel;
    logic [63:0] d;
    tap.shift_dr_i = 0; tap.capture_dr_i = 0; tap.update_dr_i = 0;
    tap.tdr_sel_i  = 0; tap.reg_sel_i = 0; tap.tdi_i = 0;
    cap_i = {32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D};
    for (int k = 0; k < N; k++) m_cfg[k] = '0;
    m_len = 0; m_sel = 0;
    repeat (3) tick();
    chk("rst_cfg", cfg_o, 0);
    chk("rst_upd", upd_o, 0);
    chk("rst_len", len_err, 0);
    chk("rst_sel", sel_err, 0);
    chk("rst_tdo", tap.tdo_o, 0);
    rst = 1'b0;
    tick();

    // Write then read back.
    scan(1, 64'h8000_00A5, W);
    scan(1, 64'h0, W);
    // Short and long scans never commit.
    scan(0, 64'hFFFF_FFFF, W-1);
    scan(0, 64'hF_FFFF_FFFF, W+2);
    // Read-only register streams cap_i and ignores the write.
    scan(2, 64'h8000_0001, W);
    // Out-of-range select captures zeros and commits nothing.
    scan(3, 64'h8000_0001, W);
    // Select wiggled mid-scan: only the captured index commits.
    scan(0, 64'h8000_0001, W);

    // Deselect in mid-scan abandons the write.
    tap.tdr_sel_i = 1; tap.reg_sel_i = 2'd1; tap.capture_dr_i = 1; tick();
    tap.capture_dr_i = 0; m_sel = 0; m_len = 0;
    d = 64'hFFFF_FFFF;
    for (int i = 0; i < W; i++) begin tap.shift_dr_i = 1; tap.tdi_i = d[i]; tick(); end
    tap.shift_dr_i = 0; tap.tdr_sel_i = 0; tick();
    tap.tdr_sel_i = 1; tap.update_dr_i = 1; tick(); tap.update_dr_i = 0;
    chk("abort_upd", upd_o, 0);
    chk("abort_cfg", cfg_o, m_flat());
    chk("abort_len", len_err, m_len);

    // Reset after 10 shift bits clears everything asynchronously.
    tap.reg_sel_i = 2'd0; tap.capture_dr_i = 1; tick(); tap.capture_dr_i = 0;
    for (int i = 0; i < 10; i++) begin tap.shift_dr_i = 1; tap.tdi_i = 1'b1; tick(); end
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) m_cfg[k] = '0;
    m_len = 0; m_sel = 0;
    chk("arst_cfg", cfg_o, 0);
    chk("arst_upd", upd_o, 0);
    chk("arst_len", len_err, 0);
    chk("arst_sel", sel_err, 0);
    chk("arst_tdo", tap.tdo_o, 0);
    tick(); rst = 1'b0;
    // Shift and update without a capture: ignored.
    d = 64'h8000_0001;
    for (int i = 0; i < W; i++) begin tap.shift_dr_i = 1; tap.tdi_i = d[i]; tick(); end
    tap.shift_dr_i = 0; tap.update_dr_i = 1; tick(); tap.update_dr_i = 0;
    chk("nocap_upd", upd_o, 0);
    chk("nocap_cfg", cfg_o, 0);
    chk("nocap_len", len_err, 0);

    // Random scans.
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0:       n = $urandom_range(0, 40);
        1:       n = W - 1;
        default: n = W;
      endcase
      d = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) d[W-1] = 1'b1;
      cap_i = {$urandom, $urandom, $urandom};
      scan(sel, d, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jtag_tdr_bank.md
# jtag_tdr_bank

Parametrised bank of NUM_REGS JTAG test data registers sharing one DR shift path, driven by the TAP state monitor. It is the next generation of the single test control register: per-register read-only/read-write modes, register select latched at capture, a shift-length check that blocks commits from short or long scans, and per-register update strobes. It sits between the TAP controller/IR decode and the digital core's test muxes. It is clocked by the JTAG test clock.

## Interface
- NUM_REGS, 4: number of data registers, 1..16.
- REG_W, 32: bits per register, 2..64. The MSB is the write-enable flag.
- RO_MASK, 0: NUM_REGS-bit mask. A set bit makes that register read-only status. Capture takes cap_i, and update is ignored.
- SEL_W, $clog2(NUM_REGS) (min 1): width of the register select.
- tclk  in  1  JTAG test clock. Posedge for shift-in and state; negedge for tdo_o only.
- test_logic_reset_i  in  1  asynchronous, active-high reset.
- shift_dr_i, capture_dr_i, update_dr_i  in  1 each  TAP state flags. At most one is high per cycle.
- tdr_sel_i  in  1  IR decode selects this bank. All DR actions are gated by it.
- reg_sel_i  in  SEL_W  register index, sampled at capture.
- tdi_i  in  1  serial data in.
- tdo_o  out  1  serial data out, changes on negedge.
- cap_i  in  NUM_REGS*REG_W  status values for read-only registers. Register k occupies bits [k*REG_W +: REG_W].
- cfg_o  out  NUM_REGS*REG_W  latched register values. The MSB of each slice is always 0.
- upd_o  out  NUM_REGS  one-cycle commit strobe per register.
- len_err_o  out  1  the last scan ended with a bit count other than REG_W.
- sel_err_o  out  1  the last capture used an out-of-range reg_sel_i.

## Operation
- All actions require tdr_sel_i = 1. Without it, the shift register, counter and select hold their values.
- **Capture:**
  - sel_q <= reg_sel_i.
  - bit_cnt <= 0.
  - len_err_o <= 0.
  - sel_err_o <= (reg_sel_i >= NUM_REGS).
  - shift_q <= cap_i slice if the selected register is read-only, otherwise its cfg slice.
  - If the select is out of range, shift_q <= 0.
- **Shift:**
  - shift_q <= {tdi_i, shift_q[REG_W-1:1]}, so the LSB leaves first.
  - bit_cnt increments and saturates at REG_W+1.
- **Update:** commit happens only if all of the following hold:
  - bit_cnt == REG_W;
  - shift_q[REG_W-1] == 1;
  - sel_q is in range;
  - the selected register is read-write.
- **On commit:** cfg slice <= {1'b0, shift_q[REG_W-2:0]}, and upd_o[sel_q] pulses.
- **On update with bit_cnt != REG_W:** len_err_o <= 1 and no commit. An MSB of 0 is a pure read, with no error and no commit.
- Updates are never committed to read-only registers. Their cfg slice stays 0.
- **State machine** (on the bank's own flags; bit_cnt is the shift-length counter):
  - IDLE → CAP on capture.
  - CAP → SHF on shift.
  - SHF → SHF on shift.
  - CAP/SHF → IDLE on update.
  - CAP/SHF → IDLE when tdr_sel_i is deasserted.
  - An update in IDLE is ignored: no commit and no error.

## Timing
- **Reset values:**
  - cfg_o = 0, upd_o = 0, len_err_o = 0, sel_err_o = 0, tdo_o = 0.
  - shift_q = 0, bit_cnt = 0, sel_q = 0, state IDLE.
- **cfg_o and upd_o:** both update on the posedge where update_dr_i is sampled. upd_o is high for exactly that one cycle.
- **tdo_o:** takes shift_q[0] on each negedge while tdr_sel_i = 1, and holds otherwise.
  - The first captured bit appears at the negedge after the capture posedge.
- **Reset mid-scan:** returns everything to reset values immediately, with no commit.
- **Scan aborted by deselect:** shift_q contents are discarded and no commit happens.
- **reg_sel_i changes after capture:** no effect until the next capture.

## Structure
- Package jtag_tdr_pkg holds:
  - the state enum (IDLE, CAP, SHF);
  - the bit_cnt width function ($clog2(REG_W+2));
  - the default RO_MASK.
- One sub-module, jtag_tdr_shifter, holds shift_q, bit_cnt and the negedge tdo_o retime. The bank wrapper holds the cfg array, select and commit logic.

## Test plan
- **Write then read:** NUM_REGS=4, REG_W=32. Select 2, shift 0x8000_00A5 (32 bits), update → upd_o=4'b0100 for 1 cycle and cfg slice 2 = 0x0000_00A5. Then capture and shift 32 bits → tdo_o returns 0x0000_00A5, LSB first.
- **Short scan:** select 1, shift 31 bits of 0xFFFF_FFFF, update → len_err_o=1, upd_o=0, cfg slice 1 unchanged. A following capture clears len_err_o.
- **Read-only register:** RO_MASK=4'b1000, cap_i slice 3 = 0x1234_5678. Capture and shift → tdo_o streams 0x1234_5678. Update with MSB=1 → no upd_o and cfg slice 3 = 0.
- **Out-of-range select:** NUM_REGS=3, reg_sel_i=3. Capture → sel_err_o=1 and 32 zeros shifted out. Update with MSB=1 → no commit.
- **Select changed mid-scan:** capture with reg_sel_i=0, change to 1 during shift, update 0x8000_0001 → only register 0 changes.
- **Reset during shift:** assert test_logic_reset_i after 10 shift bits → all outputs 0 asynchronously. A later update without capture commits nothing.
